// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package tx_arbiter_pkg;

  // Controller states; the 2-bit encoding is shared with anything that decodes them.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GUARD     = 2'd3
  } arb_state_e;

  // Guard counter width; it must hold GUARD_CYCLES-1 for GUARD_CYCLES up to 15.
  localparam int GUARD_CNT_W = 4;

  // Width of a requester index; a single requester still gets a 1-bit id.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tx_arbiter_rr_picker.sv
// Round-robin winner selection over the request vector.
// Latency: combinational.
// Backpressure: none; valid is low when no request is pending.
module rr_picker
  import tx_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_winner,
  output logic [ID_W-1:0]    winner,
  output logic               valid
);

  // Scan upward from the requester after the last winner, wrapping; first hit wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_winner) + k) % NUM_REQ);
      if (!valid && req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte requesters, round-robin.
// Latency: send rises the cycle after a grant; ack follows the transmitter dropping txdone by one cycle.
// Backpressure: send held until txdone falls; a guard gap follows every frame before the next grant.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  GUARD_CYCLES = 2,
  localparam int ID_W         = id_width(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           txdata,
  output logic                 send,
  input  logic                 txdone,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  localparam logic [GUARD_CNT_W-1:0] GUARD_LOAD = GUARD_CNT_W'(GUARD_CYCLES - 1);
  localparam logic [ID_W-1:0]        LAST_RST   = ID_W'(NUM_REQ - 1);

  arb_state_e             state_q, state_d;
  logic [7:0]             txdata_q, txdata_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [ID_W-1:0]        last_winner_q, last_winner_d;
  logic [GUARD_CNT_W-1:0] guard_cnt_q, guard_cnt_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;

  logic [ID_W-1:0]        pick_id;
  logic                   pick_vld;
  logic [7:0]             pick_byte;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req         (req),
    .last_winner (last_winner_q),
    .winner      (pick_id),
    .valid       (pick_vld)
  );

  // Byte of the requester the picker currently favours.
  always_comb begin
    pick_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == pick_id) begin
        pick_byte = req_data[8*i +: 8];
      end
    end
  end

  // Next-state logic: grant only when the transmitter is free, hold until it reacts, then guard.
  always_comb begin
    state_d       = state_q;
    txdata_d      = txdata_q;
    grant_id_d    = grant_id_q;
    last_winner_d = last_winner_q;
    guard_cnt_d   = guard_cnt_q;
    ack_d         = '0;
    case (state_q)
      ST_IDLE: begin
        // The byte is latched here so later req/req_data changes cannot disturb it.
        if (txdone && pick_vld) begin
          state_d       = ST_ISSUE;
          txdata_d      = pick_byte;
          grant_id_d    = pick_id;
          last_winner_d = pick_id;
        end
      end
      ST_ISSUE: begin
        // No timeout: send stays up until the transmitter starts the frame.
        if (!txdone) begin
          state_d = ST_WAIT_DONE;
          ack_d   = NUM_REQ'(1) << grant_id_q;
        end
      end
      ST_WAIT_DONE: begin
        if (txdone) begin
          state_d     = ST_GUARD;
          guard_cnt_d = GUARD_LOAD;
        end
      end
      ST_GUARD: begin
        // Covers the transmitter's dead cycle after txdone rises.
        if (guard_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q - GUARD_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight without an ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      txdata_q      <= 8'h00;
      grant_id_q    <= '0;
      last_winner_q <= LAST_RST;
      guard_cnt_q   <= '0;
      ack_q         <= '0;
    end else begin
      state_q       <= state_d;
      txdata_q      <= txdata_d;
      grant_id_q    <= grant_id_d;
      last_winner_q <= last_winner_d;
      guard_cnt_q   <= guard_cnt_d;
      ack_q         <= ack_d;
    end
  end

  assign ack      = ack_q;
  assign txdata   = txdata_q;
  assign grant_id = grant_id_q;
  assign send     = (state_q == ST_ISSUE);
  assign busy     = (state_q != ST_IDLE);

endmodule
